query_frame_loader: RTL and testbench

- Upstream stage of the bfis top-k search engine.
- Accepts a 32-bit word stream from the host debug link (manta register/UART word port) and assembles one search frame: sentinel, DIM query words, k, start vertex id.
- Presents the frame to bfis with a one-cycle launch pulse, then counts returned results and reports search latency in clock cycles.

---
 rtl/query_frame_loader.sv | 140 ++++++++++++++
 tb/tb_query_frame_loader.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/query_frame_loader.sv
// Host word-stream frame assembler for the bfis top-k search engine.
// Builds sentinel/query/k/vertex frames, launches a search, times the result stream.
module query_frame_loader #(
    parameter int DIM            = 4,
    parameter int MAX_K          = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] word_in,
    input  logic        word_valid_in,
    output logic        word_ready_out,
    output logic [31:0] query_out [DIM-1:0],
    output logic [15:0] k_out,
    output logic [31:0] vertex_id_out,
    output logic        valid_out,
    input  logic        result_valid_in,
    output logic        busy_out,
    output logic [31:0] cycles_out,
    output logic        cycles_valid_out,
    output logic        frame_err_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_LAUNCH  = 2'd2;
    localparam logic [1:0] S_BUSY    = 2'd3;

    localparam int          IW       = $clog2(DIM + 2);
    localparam logic [IW-1:0] IDX_K  = IW'(DIM);
    localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;
    localparam logic [32:0] TO_LIM   = 33'(TIMEOUT_CYCLES);
    localparam logic [15:0] K_MAX    = 16'(MAX_K);

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [31:0]   shadow_q [DIM-1:0];
    logic [15:0]   shadow_k;
    logic [15:0]   res_cnt;
    logic [31:0]   cnt;

    logic          accept;
    logic          is_sent;
    logic          k_ok;
    logic [32:0]   cnt_inc;
    logic          done;
    logic          timeout;

    assign word_ready_out = rst_in && (state == S_IDLE || state == S_COLLECT);
    assign valid_out      = (state == S_LAUNCH);
    assign busy_out       = (state == S_LAUNCH) || (state == S_BUSY);

    assign accept  = word_valid_in && word_ready_out;
    assign is_sent = (word_in == SENTINEL);
    assign k_ok    = (shadow_k != 16'd0) && (shadow_k <= K_MAX);
    assign cnt_inc = {1'b0, cnt} + 33'd1;

    // Completion takes priority over a timeout landing on the same cycle.
    assign done    = (state == S_BUSY) && result_valid_in
                     && (res_cnt + 16'd1 == k_out);
    assign timeout = (state == S_BUSY) && (TIMEOUT_CYCLES != 0)
                     && (cnt_inc >= TO_LIM) && !done;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= S_IDLE;
            idx              <= '0;
            shadow_k         <= '0;
            res_cnt          <= '0;
            cnt              <= '0;
            k_out            <= '0;
            vertex_id_out    <= '0;
            cycles_out       <= '0;
            cycles_valid_out <= 1'b0;
            frame_err_out    <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                shadow_q[i]  <= '0;
                query_out[i] <= '0;
            end
        end else begin
            cycles_valid_out <= 1'b0;
            frame_err_out    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept && is_sent) begin
                        state <= S_COLLECT;
                        idx   <= '0;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        if (is_sent) begin
                            idx <= '0;
                        end else if (idx < IDX_K) begin
                            for (int i = 0; i < DIM; i++)
                                if (idx == IW'(i))
                                    shadow_q[i] <= word_in;
                            idx <= idx + 1'b1;
                        end else if (idx == IDX_K) begin
                            shadow_k <= word_in[15:0];
                            idx      <= idx + 1'b1;
                        end else begin
                            idx <= '0;
                            if (k_ok) begin
                                state         <= S_LAUNCH;
                                query_out     <= shadow_q;
                                k_out         <= shadow_k;
                                vertex_id_out <= word_in;
                            end else begin
                                state         <= S_IDLE;
                                frame_err_out <= 1'b1;
                            end
                        end
                    end
                end
                S_LAUNCH: begin
                    cnt     <= '0;
                    res_cnt <= '0;
                    state   <= S_BUSY;
                end
                S_BUSY: begin
                    if (cnt != '1)
                        cnt <= cnt + 32'd1;
                    if (result_valid_in)
                        res_cnt <= res_cnt + 16'd1;
                    if (done) begin
                        cycles_out       <= (cnt == '1) ? cnt : cnt_inc[31:0];
                        cycles_valid_out <= 1'b1;
                        state            <= S_IDLE;
                    end else if (timeout) begin
                        frame_err_out <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_query_frame_loader.sv
// Scoreboard bench for query_frame_loader: expected launch/latency/error
// events are queued with stimulus and matched against monitored DUT events.
module tb_query_frame_loader;

    typedef struct packed {
        logic [1:0]   kind;
        logic [31:0]  cyc;
        logic [127:0] q;
        logic [15:0]  k;
        logic [31:0]  v;
        logic [31:0]  c;
    } ev_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid_in = 1'b0;
    logic        word_ready_out;
    logic [31:0] query_out [3:0];
    logic [15:0] k_out;
    logic [31:0] vertex_id_out;
    logic        valid_out;
    logic        result_valid_in = 1'b0;
    logic        busy_out;
    logic [31:0] cycles_out;
    logic        cycles_valid_out;
    logic        frame_err_out;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    ev_t exp_q [$];
    ev_t obs_q [$];

    query_frame_loader #(
        .DIM(4), .MAX_K(16), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .word_in(word_in), .word_valid_in(word_valid_in),
        .word_ready_out(word_ready_out),
        .query_out(query_out), .k_out(k_out),
        .vertex_id_out(vertex_id_out), .valid_out(valid_out),
        .result_valid_in(result_valid_in), .busy_out(busy_out),
        .cycles_out(cycles_out), .cycles_valid_out(cycles_valid_out),
        .frame_err_out(frame_err_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: log every pulse; kind 3 marks a pulse held two cycles.
    logic pv = 1'b0, pc = 1'b0, pe = 1'b0;
    always @(negedge clk_in) begin
        ev_t m;
        if (!rst_in) begin
            pv = 1'b0; pc = 1'b0; pe = 1'b0;
        end else begin
            if (valid_out) begin
                m = '0; m.kind = 2'd0; m.cyc = cyc;
                for (int i = 0; i < 4; i++) m.q[32*i +: 32] = query_out[i];
                m.k = k_out; m.v = vertex_id_out;
                obs_q.push_back(m);
            end
            if (cycles_valid_out) begin
                m = '0; m.kind = 2'd1; m.cyc = cyc; m.c = cycles_out;
                obs_q.push_back(m);
            end
            if (frame_err_out) begin
                m = '0; m.kind = 2'd2; m.cyc = cyc;
                obs_q.push_back(m);
            end
            if ((valid_out && pv) || (cycles_valid_out && pc)
                || (frame_err_out && pe)) begin
                m = '0; m.kind = 2'd3; m.cyc = cyc;
                obs_q.push_back(m);
            end
            pv = valid_out; pc = cycles_valid_out; pe = frame_err_out;
        end
    end

    function automatic ev_t exp_launch(input logic [31:0] ws [$], input int at);
        ev_t e = '0;
        int  sz = ws.size();
        logic [31:0] kw = ws[sz-2];
        e.kind = 2'd0;
        e.cyc  = at;
        for (int i = 0; i < 4; i++) e.q[32*i +: 32] = ws[sz-6+i];
        e.k = kw[15:0];
        e.v = ws[sz-1];
        return e;
    endfunction

    function automatic ev_t exp_ev(input logic [1:0] kind, input int at,
                                   input logic [31:0] c);
        ev_t e = '0;
        e.kind = kind; e.cyc = at; e.c = c;
        return e;
    endfunction

    task automatic send(input logic [31:0] w);
        int n = 0;
        @(negedge clk_in);
        word_valid_in = 1'b1;
        word_in = w;
        while (!word_ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        @(posedge clk_in);
        #1;
    endtask

    // Returns the cycle index of the LAUNCH cycle (or of the error pulse).
    task automatic send_frame(input logic [31:0] ws [$], output int at);
        foreach (ws[i]) send(ws[i]);
        at = cyc;
        @(negedge clk_in);
        word_valid_in = 1'b0;
    endtask

    // Called in the LAUNCH cycle; drives results on the listed BUSY cycles.
    task automatic results(input int last, input int hits [$]);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk_in);
            result_valid_in = 1'b0;
            foreach (hits[j]) if (hits[j] == c) result_valid_in = 1'b1;
        end
        @(negedge clk_in);
        result_valid_in = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] qor = '0;
        repeat (3) @(negedge clk_in);
        foreach (query_out[i]) qor |= query_out[i];
        checks++;
        if ({valid_out, cycles_valid_out, frame_err_out, busy_out, word_ready_out} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                {valid_out, cycles_valid_out, frame_err_out, busy_out, word_ready_out});
        end
        checks++;
        if ({k_out, vertex_id_out, cycles_out, qor} !== 112'd0) begin
            errors++;
            $display("FAIL reset_regs got k=%0d v=%0d c=%0d q=%h exp=0",
                k_out, vertex_id_out, cycles_out, qor);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({word_ready_out, busy_out} !== 2'b10) begin
            errors++;
            $display("FAIL idle_ready got=%b exp=10", {word_ready_out, busy_out});
        end
    endtask

    task automatic test_launch_complete;
        logic [31:0] ws [$];
        int hits [$];
        int a;
        ev_t eo, ee;
        ws = '{32'hFFFF_FFFF, 5, 7, 1, 1, 4, 1};
        hits = '{3, 5, 8, 10};
        send_frame(ws, a);
        exp_q.push_back(exp_launch(ws, a));
        checks++;
        if ({word_ready_out, busy_out} !== 2'b01) begin
            errors++;
            $display("FAIL launch_ready got=%b exp=01", {word_ready_out, busy_out});
        end
        results(10, hits);
        exp_q.push_back(exp_ev(2'd1, a + 11, 32'd10));
        checks++;
        if ({word_ready_out, busy_out} !== 2'b10) begin
            errors++;
            $display("FAIL done_idle got=%b exp=10", {word_ready_out, busy_out});
        end
        repeat (3) @(negedge clk_in);
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL launch_ev missing exp=%h", ee);
            end else begin
                eo = obs_q.pop_front();
                if (eo !== ee) begin
                    errors++;
                    $display("FAIL launch_ev got=%h exp=%h", eo, ee);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL launch_extra got=%0d exp=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_resync;
        logic [31:0] ws [$];
        int hits [$];
        int a;
        ev_t eo, ee;
        ws = '{3, 9, 32'hFFFF_FFFF, 5, 7, 32'hFFFF_FFFF, 2, 2, 2, 2, 1, 9};
        hits = '{1};
        send_frame(ws, a);
        exp_q.push_back(exp_launch(ws, a));
        results(1, hits);
        exp_q.push_back(exp_ev(2'd1, a + 2, 32'd1));
        repeat (3) @(negedge clk_in);
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL resync_ev missing exp=%h", ee);
            end else begin
                eo = obs_q.pop_front();
                if (eo !== ee) begin
                    errors++;
                    $display("FAIL resync_ev got=%h exp=%h", eo, ee);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL resync_extra got=%0d exp=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_bad_k;
        logic [31:0] ws [$];
        int a;
        ev_t eo, ee;
        ws = '{32'hFFFF_FFFF, 1, 2, 3, 4, 0, 5};
        send_frame(ws, a);
        exp_q.push_back(exp_ev(2'd2, a, 32'd0));
        repeat (2) @(negedge clk_in);
        ws = '{32'hFFFF_FFFF, 1, 2, 3, 4, 32'hABCD_0011, 5};
        send_frame(ws, a);
        exp_q.push_back(exp_ev(2'd2, a, 32'd0));
        repeat (3) @(negedge clk_in);
        checks++;
        if ({query_out[3], query_out[2], query_out[1], query_out[0], k_out, vertex_id_out}
            !== {32'd2, 32'd2, 32'd2, 32'd2, 16'd1, 32'd9}) begin
            errors++;
            $display("FAIL badk_hold got q0=%0d k=%0d v=%0d exp q0=2 k=1 v=9",
                query_out[0], k_out, vertex_id_out);
        end
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL badk_ev missing exp=%h", ee);
            end else begin
                eo = obs_q.pop_front();
                if (eo !== ee) begin
                    errors++;
                    $display("FAIL badk_ev got=%h exp=%h", eo, ee);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL badk_extra got=%0d exp=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_timeout;
        logic [31:0] ws [$];
        int hits [$];
        int a;
        ev_t eo, ee;
        ws = '{32'hFFFF_FFFF, 10, 20, 30, 40, 4, 77};
        hits = '{3, 5};
        send_frame(ws, a);
        exp_q.push_back(exp_launch(ws, a));
        exp_q.push_back(exp_ev(2'd2, a + 51, 32'd0));
        results(10, hits);
        repeat (45) @(negedge clk_in);
        // Completion on the very cycle the timeout would fire.
        ws = '{32'hFFFF_FFFF, 11, 12, 13, 14, 1, 78};
        hits = '{50};
        send_frame(ws, a);
        exp_q.push_back(exp_launch(ws, a));
        results(50, hits);
        exp_q.push_back(exp_ev(2'd1, a + 51, 32'd50));
        ws = '{32'hFFFF_FFFF, 21, 22, 23, 24, 16, 79};
        hits = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        send_frame(ws, a);
        exp_q.push_back(exp_launch(ws, a));
        results(16, hits);
        exp_q.push_back(exp_ev(2'd1, a + 17, 32'd16));
        repeat (3) @(negedge clk_in);
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL timeout_ev missing exp=%h", ee);
            end else begin
                eo = obs_q.pop_front();
                if (eo !== ee) begin
                    errors++;
                    $display("FAIL timeout_ev got=%h exp=%h", eo, ee);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_extra got=%0d exp=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] ws [$];
        int hits [$];
        int a;
        ev_t eo, ee;
        logic [31:0] qor;
        send(32'hFFFF_FFFF);
        send(32'd1);
        send(32'd2);
        @(negedge clk_in);
        word_valid_in = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        qor = '0;
        foreach (query_out[i]) qor |= query_out[i];
        checks++;
        if ({k_out, vertex_id_out, cycles_out, qor, word_ready_out, busy_out} !== 114'd0) begin
            errors++;
            $display("FAIL rst_collect got k=%0d v=%0d c=%0d q=%h rdy=%b exp=0",
                k_out, vertex_id_out, cycles_out, qor, word_ready_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        ws = '{32'hFFFF_FFFF, 6, 6, 6, 6, 2, 3};
        send_frame(ws, a);
        exp_q.push_back(exp_launch(ws, a));
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        qor = '0;
        foreach (query_out[i]) qor |= query_out[i];
        checks++;
        if ({k_out, vertex_id_out, cycles_out, qor, busy_out, valid_out} !== 114'd0) begin
            errors++;
            $display("FAIL rst_busy got k=%0d v=%0d c=%0d q=%h busy=%b exp=0",
                k_out, vertex_id_out, cycles_out, qor, busy_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        ws = '{32'hFFFF_FFFF, 8, 9, 10, 11, 1, 4};
        hits = '{2};
        send_frame(ws, a);
        exp_q.push_back(exp_launch(ws, a));
        results(2, hits);
        exp_q.push_back(exp_ev(2'd1, a + 3, 32'd2));
        repeat (3) @(negedge clk_in);
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL rstmid_ev missing exp=%h", ee);
            end else begin
                eo = obs_q.pop_front();
                if (eo !== ee) begin
                    errors++;
                    $display("FAIL rstmid_ev got=%h exp=%h", eo, ee);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_extra got=%0d exp=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_launch_complete();
        test_resync();
        test_bad_k();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1);
    end

endmodule
